// File: rtl/psc_pkg.sv
// Shared types and constants for the pattern scan controller.
// Optional build macro: PSC_TIMEOUT_EN (enables the RUN idle timeout).
package psc_pkg;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 3;
  localparam int CNT_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Select the low len+1 bits of the history and the pattern.
  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
    return {MAX_LEN{1'b1}} >> (3'd7 - len);
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// Serial history shift register, received-bit counter and masked pattern compare.
// The match flag is evaluated on the history as it will be after the offered bit shifts in.
module seq_match_core
  import psc_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_clear,
  input  logic               i_shift,
  input  logic               i_bit,
  input  logic [MAX_LEN-1:0] i_pattern,
  input  logic [LEN_W-1:0]   i_len,
  output logic               o_match_next
);

  logic [MAX_LEN-1:0] r_history;
  logic [3:0]         r_bit_cnt;
  logic [MAX_LEN-1:0] w_history_next;
  logic [MAX_LEN-1:0] w_mask;
  logic [3:0]         w_bit_cnt_next;
  logic               w_unused_msb;

  // The oldest bit falls off the end and never takes part in a compare.
  assign w_unused_msb   = r_history[MAX_LEN-1];
  assign w_history_next = {r_history[MAX_LEN-2:0], i_bit};
  assign w_bit_cnt_next = (r_bit_cnt == 4'(MAX_LEN)) ? r_bit_cnt : r_bit_cnt + 4'd1;
  assign w_mask         = len_mask(i_len);

  // At least len+1 bits seen, i.e. count > len.
  assign o_match_next = (w_bit_cnt_next > {1'b0, i_len}) &&
                        (((w_history_next ^ i_pattern) & w_mask) == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_history <= '0;
      r_bit_cnt <= '0;
    end else if (i_clear) begin
      r_history <= '0;
      r_bit_cnt <= '0;
    end else if (i_shift) begin
      r_history <= w_history_next;
      r_bit_cnt <= w_bit_cnt_next;
    end
  end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Serial pattern scanner: configure, start, count overlapping matches until target.
// Optional build macro: PSC_TIMEOUT_EN adds a TIMEOUT_CYCLES idle limit while scanning.
module pattern_scan_ctrl
  import psc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               start,
  input  logic               bit_valid,
  output logic               bit_ready,
  input  logic               bit_in,
  output logic               busy,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               done,
  output logic               timeout
);

  state_t             r_state;
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic [CNT_W-1:0]   r_target;
  logic [CNT_W-1:0]   r_match_count;
  logic               r_match;
  logic               r_bit_ready;

  logic               w_accept;
  logic               w_clear;
  logic               w_match_next;
  logic [CNT_W-1:0]   w_target_eff;
  logic               w_last_match;

  assign w_accept     = r_bit_ready & bit_valid;
  assign w_clear      = (r_state == ST_ARMED) & start;
  assign w_target_eff = (r_target == '0) ? CNT_W'(1) : r_target;
  assign w_last_match = (r_match_count + CNT_W'(1)) == w_target_eff;

  seq_match_core u_core (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (w_clear),
    .i_shift      (w_accept),
    .i_bit        (bit_in),
    .i_pattern    (r_pattern),
    .i_len        (r_len),
    .o_match_next (w_match_next)
  );

`ifdef PSC_TIMEOUT_EN
  localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_idle;
  logic        r_timeout;
`else
  logic [15:0] w_unused_timeout;
  assign w_unused_timeout = 16'(TIMEOUT_CYCLES);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_pattern     <= '0;
      r_len         <= '0;
      r_target      <= '0;
      r_match_count <= '0;
      r_match       <= 1'b0;
      r_bit_ready   <= 1'b0;
`ifdef PSC_TIMEOUT_EN
      r_idle        <= '0;
      r_timeout     <= 1'b0;
`endif
    end else begin
      r_match <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cfg_valid) begin
            r_pattern <= cfg_pattern;
            r_len     <= cfg_len;
            r_target  <= cfg_target;
            r_state   <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (start) begin
            r_match_count <= '0;
            r_bit_ready   <= 1'b1;
            r_state       <= ST_RUN;
`ifdef PSC_TIMEOUT_EN
            r_idle        <= '0;
`endif
          end
        end
        ST_RUN: begin
          if (w_accept) begin
`ifdef PSC_TIMEOUT_EN
            r_idle <= '0;
`endif
            if (w_match_next) begin
              r_match       <= 1'b1;
              r_match_count <= r_match_count + CNT_W'(1);
              // Stop accepting at once so the target-reaching bit is the last one.
              if (w_last_match) r_bit_ready <= 1'b0;
            end
          end else if (!r_bit_ready) begin
            // Target was reached on the previous edge; finish now.
            r_state <= ST_DONE;
          end
`ifdef PSC_TIMEOUT_EN
          else if (r_idle == IDLE_LAST) begin
            r_state     <= ST_DONE;
            r_timeout   <= 1'b1;
            r_bit_ready <= 1'b0;
          end else begin
            r_idle <= r_idle + 16'd1;
          end
`endif
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
`ifdef PSC_TIMEOUT_EN
          r_timeout <= 1'b0;
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cfg_ready   = (r_state == ST_IDLE);
  assign busy        = (r_state == ST_ARMED) || (r_state == ST_RUN);
  assign done        = (r_state == ST_DONE);
  assign bit_ready   = r_bit_ready;
  assign match       = r_match;
  assign match_count = r_match_count;
`ifdef PSC_TIMEOUT_EN
  assign timeout     = r_timeout;
`else
  assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Randomized bench for pattern_scan_ctrl against a bit-list reference model.
// Honours PSC_TIMEOUT_EN for the idle-timeout scenario.
module tb_pattern_scan_ctrl;

  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_valid, cfg_ready;
  logic [7:0] cfg_pattern;
  logic [2:0] cfg_len;
  logic [7:0] cfg_target;
  logic       start, bit_valid, bit_ready, bit_in;
  logic       busy, match, done, timeout;
  logic [7:0] match_count;

  int n_checks = 0;
  int n_errors = 0;
  bit stim[64];
  int nstim;

  pattern_scan_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_target(cfg_target), .start(start),
    .bit_valid(bit_valid), .bit_ready(bit_ready), .bit_in(bit_in),
    .busy(busy), .match(match), .match_count(match_count),
    .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Oldest bit first: stim[0] = v[n-1].
  task automatic load_bits(input logic [63:0] v, input int n);
    nstim = n;
    for (int i = 0; i < n; i++) stim[i] = v[n-1-i];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input logic [7:0] pat, input logic [2:0] len, input logic [7:0] tgt);
    check("cfg_ready_idle", 32'(cfg_ready), 1);
    cfg_valid = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_target = tgt;
    step();
    cfg_valid = 1'b0; cfg_pattern = 8'($urandom); cfg_len = 3'($urandom); cfg_target = 8'($urandom);
    check("armed_busy", 32'(busy), 1);
    check("armed_cfg_ready", 32'(cfg_ready), 0);
    check("armed_bit_ready", 32'(bit_ready), 0);
    repeat ($urandom_range(0, 2)) step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("run_bit_ready", 32'(bit_ready), 1);
    check("run_count_clear", 32'(match_count), 0);
    check("run_busy", 32'(busy), 1);
  endtask

  // Reference: a match is the last len+1 received bits equalling pattern bits (bit 0 newest).
  task automatic scan(input logic [7:0] pat, input logic [2:0] len, input logic [7:0] tgt,
                      input bit junk, output bit finished);
    int L, T, nm, end_idx, idx, exp_cnt, cyc;
    bit mflag[64];
    bit ok, bv;
    L = int'(len) + 1;
    T = (tgt == 0) ? 1 : int'(tgt);
    nm = 0; end_idx = -1;
    for (int i = 0; i < nstim; i++) begin
      mflag[i] = 1'b0;
      if (end_idx < 0 && i + 1 >= L) begin
        ok = 1'b1;
        for (int j = 0; j < L; j++) if (stim[i-j] != pat[j]) ok = 1'b0;
        mflag[i] = ok;
        if (ok) begin
          nm++;
          if (nm == T) end_idx = i;
        end
      end
    end
    idx = 0; exp_cnt = 0; cyc = 0;
    while (idx < nstim && (end_idx < 0 || idx <= end_idx)) begin
      if (++cyc > 1000) begin
        check("scan_budget", 0, 1);
        break;
      end
      bv = ($urandom_range(0, 3) != 0);
      bit_valid = bv;
      bit_in = bv ? stim[idx] : 1'($urandom);
      if (junk) begin
        cfg_valid = 1'($urandom); start = 1'($urandom);
        cfg_pattern = 8'($urandom); cfg_len = 3'($urandom); cfg_target = 8'($urandom);
      end
      step();
      if (bv) begin
        if (mflag[idx]) exp_cnt++;
        check("match", 32'(match), 32'(mflag[idx]));
        idx++;
      end else begin
        check("match_gap", 32'(match), 0);
      end
      check("match_count", 32'(match_count), 32'(exp_cnt));
      check("bit_ready", 32'(bit_ready), 32'(!(end_idx >= 0 && idx > end_idx)));
      check("cfg_ready_run", 32'(cfg_ready), 0);
      check("done_run", 32'(done), 0);
    end
    bit_valid = 1'b0; cfg_valid = 1'b0; start = 1'b0;
    finished = (end_idx >= 0);
    if (finished) begin
      step();
      check("done", 32'(done), 1);
      check("done_busy", 32'(busy), 0);
      check("done_match", 32'(match), 0);
      check("done_timeout", 32'(timeout), 0);
      step();
      check("done_clear", 32'(done), 0);
      check("idle_cfg_ready", 32'(cfg_ready), 1);
      check("final_count", 32'(match_count), 32'(T));
    end
    $display("scan pat=%02h len=%0d tgt=%0d bits=%0d expected_matches=%0d finished=%0d",
             pat, len, tgt, nstim, exp_cnt, finished);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_count", 32'(match_count), 0);
    check("rst_cfg_ready", 32'(cfg_ready), 1);
    check("rst_bit_ready", 32'(bit_ready), 0);
    step();
    reset = 1'b0;
    check("rst_match", 32'(match), 0);
    check("rst_done", 32'(done), 0);
  endtask

  initial begin
    bit fin;
    logic [7:0] rp, rt;
    logic [2:0] rl;
    reset = 1'b1; cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_target = '0;
    start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    step(); step();
    check("reset_cfg_ready", 32'(cfg_ready), 1);
    check("reset_bit_ready", 32'(bit_ready), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_match", 32'(match), 0);
    check("reset_done", 32'(done), 0);
    check("reset_timeout", 32'(timeout), 0);
    check("reset_count", 32'(match_count), 0);
    reset = 1'b0;
    step();

    // Overlapping 1011 in 1011011, target 2.
    configure(8'b0000_1011, 3'd3, 8'd2);
    load_bits(64'b1011011, 7);
    scan(8'b0000_1011, 3'd3, 8'd2, 1'b0, fin);
    check("ovl_finished", 32'(fin), 1);

    // Target 0 behaves as 1.
    configure(8'h01, 3'd0, 8'd0);
    load_bits(64'b1, 1);
    scan(8'h01, 3'd0, 8'd0, 1'b0, fin);
    check("t0_finished", 32'(fin), 1);

    // Full 8-bit pattern needs all 8 bits.
    configure(8'hA5, 3'd7, 8'd1);
    load_bits(64'hA5, 8);
    scan(8'hA5, 3'd7, 8'd1, 1'b0, fin);
    check("len8_finished", 32'(fin), 1);

    // Config and start offered during RUN must be ignored.
    configure(8'h03, 3'd1, 8'd3);
    load_bits(64'h0000_0000_000F_3B7F, 24);
    scan(8'h03, 3'd1, 8'd3, 1'b1, fin);
    if (!fin) apply_reset();

    // Reset mid-scan after three matches.
    configure(8'h01, 3'd0, 8'd10);
    load_bits(64'b111, 3);
    scan(8'h01, 3'd0, 8'd10, 1'b0, fin);
    check("pre_reset_count", 32'(match_count), 3);
    apply_reset();

    for (int it = 0; it < 10; it++) begin
      rl = 3'($urandom_range(0, 3));
      rp = 8'($urandom);
      rt = 8'($urandom_range(0, 4));
      nstim = $urandom_range(8, 40);
      for (int i = 0; i < nstim; i++) stim[i] = 1'($urandom);
      configure(rp, rl, rt);
      scan(rp, rl, rt, 1'($urandom), fin);
      if (!fin) apply_reset();
    end

    // Idle input in RUN.
    configure(8'h01, 3'd0, 8'd1);
`ifdef PSC_TIMEOUT_EN
    for (int k = 1; k <= TO; k++) begin
      step();
      check("to_done", 32'(done), 32'(k == TO));
      check("to_flag", 32'(timeout), 32'(k == TO));
    end
    step();
    check("to_clear", 32'(timeout), 0);
    check("to_idle", 32'(cfg_ready), 1);
`else
    for (int k = 1; k <= 2 * TO; k++) begin
      step();
      check("wait_done", 32'(done), 0);
      check("wait_timeout", 32'(timeout), 0);
    end
    check("wait_busy", 32'(busy), 1);
    apply_reset();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
